// File: rtl/aidc_lite_ahb_arbiter.sv
// ============================================================================
// aidc_lite_ahb_arbiter
//
// Purpose:
//   AHB bus arbiter for NUM_MASTERS masters.
//   - Registered one-hot grant.
//   - Fixed-length bursts are never broken.
//   - Locked sequences keep the bus with their owner.
//   - The grant moves only at an arbitration point.
//
// Configuration:
//   AIDC_LITE_ARB_FIXED_PRIO_EN
//     defined   : fixed priority; the lowest requesting index wins.
//     undefined : round-robin. The search starts one past the current owner,
//                 so an owner that is still requesting loses to any other
//                 requester.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   hbusreq_i    in   [NUM_MASTERS] per-master bus request
//   hlock_i      in   [NUM_MASTERS] per-master locked-transfer request
//   htrans_i     in   [2] muxed HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//   hburst_i     in   [3] muxed HBURST
//   hready_i     in   bus HREADY; a beat is accepted when high
//   hgrant_o     out  [NUM_MASTERS] registered one-hot grant
//   hmaster_o    out  [clog2(NUM_MASTERS)] address-phase owner index
//   hmastlock_o  out  current address phase is locked
//   dbg_state_o  out  [2] FSM state (0 OPEN, 1 BURST, 2 LOCK)
//
// Handshake:
//   A beat is accepted on a rising edge where hready_i=1. Stalled beats
//   (hready_i=0) have no effect on the grant, the state or the beat counter.
//   hmaster_o and hmastlock_o advance only on accepted edges.
// ============================================================================
module aidc_lite_ahb_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         hbusreq_i,
    input  logic [NUM_MASTERS-1:0]         hlock_i,
    input  logic [1:0]                     htrans_i,
    input  logic [2:0]                     hburst_i,
    input  logic                           hready_i,
    output logic [NUM_MASTERS-1:0]         hgrant_o,
    output logic [$clog2(NUM_MASTERS)-1:0] hmaster_o,
    output logic                           hmastlock_o,
    output logic [1:0]                     dbg_state_o
);

    localparam int                     MW      = $clog2(NUM_MASTERS);
    localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        S_OPEN  = 2'd0,
        S_BURST = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [3:0]               r_beat_cnt;
    logic [MW-1:0]            r_grant_idx;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [MW-1:0]            r_master;
    logic                     r_mastlock;

    state_t                   w_state_nxt;
    logic [3:0]               w_beat_nxt;
    logic [MW-1:0]            w_grant_idx_nxt;
    logic                     w_arb_point;
    logic [4:0]               w_burst_len;
    logic                     w_pick_found;
    logic [MW-1:0]            w_pick_idx;

    // Fixed burst length.
    // SINGLE and INCR both map to 1: neither opens a counted burst.
    always_comb begin
        case (hburst_i)
            3'b010, 3'b011: w_burst_len = 5'd4;
            3'b100, 3'b101: w_burst_len = 5'd8;
            3'b110, 3'b111: w_burst_len = 5'd16;
            default:        w_burst_len = 5'd1;
        endcase
    end

`ifdef AIDC_LITE_ARB_FIXED_PRIO_EN
    // Fixed priority.
    // The loop walks downward, so the lowest requesting index is the last
    // one written and therefore wins.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = DEF_IDX;
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (hbusreq_i[j]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = MW'(j);
            end
        end
    end
`else
    // Round-robin.
    // Offsets are walked from farthest to nearest, so the first requester
    // after the owner ends up as the final write. The owner itself sits at
    // offset NUM_MASTERS, which makes it the last choice.
    int            w_rr_sum;
    logic [MW-1:0] w_rr_idx;

    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = DEF_IDX;
        w_rr_sum     = 0;
        w_rr_idx     = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            w_rr_sum = int'(r_grant_idx) + i;
            if (w_rr_sum >= NUM_MASTERS) begin
                w_rr_sum = w_rr_sum - NUM_MASTERS;
            end
            w_rr_idx = w_rr_sum[MW-1:0];
            if (hbusreq_i[w_rr_idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_rr_idx;
            end
        end
    end
`endif

    // Next-state logic.
    // Arbitration points:
    //   OPEN/LOCK : hready_i=1 and (IDLE, or an accepted SINGLE NONSEQ, or
    //               the owner has dropped its request).
    //   BURST     : the final accepted SEQ.
    // An accepted fixed-length NONSEQ takes precedence and opens a burst.
    always_comb begin
        w_state_nxt     = r_state;
        w_beat_nxt      = r_beat_cnt;
        w_grant_idx_nxt = r_grant_idx;
        w_arb_point     = 1'b0;

        case (r_state)
            S_BURST: begin
                if (hready_i && htrans_i == HT_SEQ) begin
                    if (r_beat_cnt == 4'd1) begin
                        w_arb_point = 1'b1;
                    end else begin
                        w_beat_nxt = r_beat_cnt - 4'd1;
                    end
                end
            end
            default: begin
                if (hready_i && htrans_i == HT_NONSEQ && w_burst_len > 5'd1) begin
                    w_state_nxt = S_BURST;
                    w_beat_nxt  = 4'(w_burst_len - 5'd1);
                end else if (hready_i &&
                             (htrans_i == HT_IDLE ||
                              (htrans_i == HT_NONSEQ && hburst_i == HB_SINGLE) ||
                              !hbusreq_i[r_grant_idx])) begin
                    w_arb_point = 1'b1;
                end
            end
        endcase

        if (w_arb_point) begin
            w_beat_nxt = 4'd0;
            if (hlock_i[r_grant_idx]) begin
                // A locked owner keeps the bus.
                w_state_nxt = S_LOCK;
            end else begin
                w_state_nxt     = S_OPEN;
                w_grant_idx_nxt = w_pick_found ? w_pick_idx : DEF_IDX;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_OPEN;
            r_beat_cnt  <= 4'd0;
            r_grant_idx <= DEF_IDX;
            r_grant     <= DEF_OH;
            r_master    <= DEF_IDX;
            r_mastlock  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_grant     <= NUM_MASTERS'(1) << w_grant_idx_nxt;
            if (hready_i) begin
                r_master   <= r_grant_idx;
                r_mastlock <= hlock_i[r_grant_idx];
            end
        end
    end

    assign hgrant_o    = r_grant;
    assign hmaster_o   = r_master;
    assign hmastlock_o = r_mastlock;
    assign dbg_state_o = r_state;

endmodule
